// File: rtl/hls2x8_3_dot8_acc.sv
// Streaming dot-product accumulator: sums N_TERMS signed
// products per row and hands each row sum downstream.
module hls2x8_3_dot8_acc #(
  parameter int DIN_WIDTH = 16,
  parameter int N_TERMS   = 8,
  parameter int N_ROWS    = 2,
  localparam int RW = (N_ROWS > 1) ? $clog2(N_ROWS) : 1,
  localparam int CW = (N_TERMS > 1) ? $clog2(N_TERMS) : 1
) (
  input  logic                 ap_clk,
  input  logic                 ap_rst,
  input  logic                 clr,
  input  logic [DIN_WIDTH-1:0] prod_din,
  input  logic                 prod_vld,
  output logic                 prod_rdy,
  output logic [DIN_WIDTH-1:0] sum_dout,
  output logic [RW-1:0]        sum_row,
  output logic                 sum_last,
  output logic                 sum_vld,
  input  logic                 sum_rdy
);

  typedef enum logic {
    ACC  = 1'b0,
    HOLD = 1'b1
  } state_t;

  localparam logic [CW-1:0] CNT_LAST = CW'(N_TERMS - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(N_ROWS - 1);

  state_t               state_q;
  state_t               state_d;
  logic [DIN_WIDTH-1:0] acc_q;
  logic [CW-1:0]        cnt_q;
  logic [RW-1:0]        row_q;
  logic                 accept;
  logic                 last;
  logic                 xfer;

  // Handshake outputs come straight from the state register.
  assign prod_rdy = (state_q == ACC);
  assign sum_vld  = (state_q == HOLD);

  assign accept = prod_vld & (state_q == ACC);
  assign last   = accept & (cnt_q == CNT_LAST);
  assign xfer   = sum_rdy & (state_q == HOLD);

  // Next state: close a row into HOLD, leave on transfer;
  // clr always forces a fresh ACC.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ACC:  if (last) state_d = HOLD;
      HOLD: if (xfer) state_d = ACC;
    endcase
    if (clr) state_d = ACC;
  end

  // State register.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) state_q <= ACC;
    else        state_q <= state_d;
  end

  // Accumulator, term/row counters and the held row sum.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      acc_q    <= '0;
      cnt_q    <= '0;
      row_q    <= '0;
      sum_dout <= '0;
      sum_row  <= '0;
      sum_last <= 1'b0;
    end else if (clr) begin
      acc_q <= '0;
      cnt_q <= '0;
      row_q <= '0;
    end else if (accept) begin
      if (last) begin
        sum_dout <= acc_q + prod_din;
        sum_row  <= row_q;
        sum_last <= (row_q == ROW_LAST);
        acc_q    <= '0;
        cnt_q    <= '0;
      end else begin
        acc_q <= acc_q + prod_din;
        cnt_q <= cnt_q + 1'b1;
      end
    end else if (xfer) begin
      row_q <= (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_hls2x8_3_dot8_acc.sv
// Bench for hls2x8_3_dot8_acc: vector table, corner
// sequences and a random run against a row-sum model.
module tb_hls2x8_3_dot8_acc;

  logic        ap_clk = 1'b0;
  logic        ap_rst = 1'b1;
  logic        clr = 1'b0;
  logic [15:0] prod_din = '0;
  logic        prod_vld = 1'b0;
  logic        prod_rdy;
  logic [15:0] sum_dout;
  logic        sum_row;
  logic        sum_last;
  logic        sum_vld;
  logic        sum_rdy = 1'b0;

  int n_cmp = 0;
  int n_err = 0;

  hls2x8_3_dot8_acc dut (
    .ap_clk   (ap_clk),
    .ap_rst   (ap_rst),
    .clr      (clr),
    .prod_din (prod_din),
    .prod_vld (prod_vld),
    .prod_rdy (prod_rdy),
    .sum_dout (sum_dout),
    .sum_row  (sum_row),
    .sum_last (sum_last),
    .sum_vld  (sum_vld),
    .sum_rdy  (sum_rdy)
  );

  always #5 ap_clk = ~ap_clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  typedef struct packed {
    logic [7:0][15:0] p;
    logic [15:0]      sum;
    logic             row;
    logic             last;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h expected %0h",
               name, $time, act, exp);
    end
  endtask

  task automatic push(input logic [15:0] d);
    prod_din = d;
    prod_vld = 1'b1;
    @(posedge ap_clk);
    #1;
    prod_vld = 1'b0;
  endtask

  task automatic push_n(input int n, input logic [15:0] d);
    for (int i = 0; i < n; i++) push(d);
  endtask

  task automatic expect_sum(input string name,
                            input logic [15:0] s,
                            input logic r,
                            input logic l);
    check({name, ".vld"}, sum_vld, 1'b1);
    check({name, ".rdy"}, prod_rdy, 1'b0);
    check({name, ".sum"}, sum_dout, s);
    check({name, ".row"}, sum_row, r);
    check({name, ".last"}, sum_last, l);
  endtask

  task automatic xfer(input string name);
    sum_rdy = 1'b1;
    @(posedge ap_clk);
    #1;
    sum_rdy = 1'b0;
    check({name, ".vld_drop"}, sum_vld, 1'b0);
    check({name, ".rdy_back"}, prod_rdy, 1'b1);
  endtask

  // random-run model state
  logic [15:0] terms[$];
  logic [15:0] exp_sum;
  logic [15:0] acc_m;
  logic        exp_row;
  logic        exp_last;
  logic        pending;
  int          rows_done;

  initial begin
    // table: 1..8, 5s, -3s, 5s, 0x7FFF, 0x8000
    for (int t = 0; t < 8; t++) begin
      vecs[0].p[t] = 16'(t + 1);
      vecs[1].p[t] = 16'd5;
      vecs[2].p[t] = 16'hFFFD;
      vecs[3].p[t] = 16'd5;
      vecs[4].p[t] = 16'h7FFF;
      vecs[5].p[t] = 16'h8000;
    end
    vecs[0].sum = 16'd36;   vecs[0].row = 0; vecs[0].last = 0;
    vecs[1].sum = 16'd40;   vecs[1].row = 1; vecs[1].last = 1;
    vecs[2].sum = 16'hFFE8; vecs[2].row = 0; vecs[2].last = 0;
    vecs[3].sum = 16'd40;   vecs[3].row = 1; vecs[3].last = 1;
    vecs[4].sum = 16'hFFF8; vecs[4].row = 0; vecs[4].last = 0;
    vecs[5].sum = 16'h0000; vecs[5].row = 1; vecs[5].last = 1;

    // reset state
    repeat (2) @(posedge ap_clk);
    #1;
    check("rst.rdy", prod_rdy, 1'b1);
    check("rst.vld", sum_vld, 1'b0);
    check("rst.sum", sum_dout, 16'h0);
    check("rst.row", sum_row, 1'b0);
    check("rst.last", sum_last, 1'b0);
    ap_rst = 1'b0;
    @(posedge ap_clk);
    #1;

    // table vectors
    for (int v = 0; v < 6; v++) begin
      for (int t = 0; t < 8; t++) push(vecs[v].p[t]);
      expect_sum($sformatf("vec%0d", v), vecs[v].sum,
                 vecs[v].row, vecs[v].last);
      xfer($sformatf("vec%0d", v));
    end

    // backpressure: no product taken while holding
    push_n(8, 16'd3);
    expect_sum("bp", 16'd24, 1'b0, 1'b0);
    prod_din = 16'd9;
    prod_vld = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge ap_clk);
      #1;
      check("bp.hold_sum", sum_dout, 16'd24);
      check("bp.hold_rdy", prod_rdy, 1'b0);
      check("bp.hold_vld", sum_vld, 1'b1);
    end
    sum_rdy = 1'b1;
    @(posedge ap_clk);
    #1;
    sum_rdy = 1'b0;
    check("bp.xfer_rdy", prod_rdy, 1'b1);
    check("bp.xfer_vld", sum_vld, 1'b0);
    push_n(8, 16'd1);
    expect_sum("bp_next", 16'd8, 1'b1, 1'b1);
    xfer("bp_next");

    // clr mid-row with a valid product, row was 1
    push_n(8, 16'd1);
    expect_sum("pre_clr", 16'd8, 1'b0, 1'b0);
    xfer("pre_clr");
    push_n(3, 16'd7);
    clr = 1'b1;
    push(16'd100);
    clr = 1'b0;
    check("clr.rdy", prod_rdy, 1'b1);
    check("clr.vld", sum_vld, 1'b0);
    push_n(8, 16'd2);
    expect_sum("clr", 16'd16, 1'b0, 1'b0);
    xfer("clr");

    // async reset between edges while holding
    push_n(8, 16'd4);
    expect_sum("arst_pre", 16'd32, 1'b1, 1'b1);
    #3;
    ap_rst = 1'b1;
    #1;
    check("arst.vld", sum_vld, 1'b0);
    check("arst.rdy", prod_rdy, 1'b1);
    check("arst.sum", sum_dout, 16'h0);
    check("arst.row", sum_row, 1'b0);
    check("arst.last", sum_last, 1'b0);
    #2;
    ap_rst = 1'b0;
    @(posedge ap_clk);
    #1;
    for (int t = 0; t < 8; t++) push(16'(t + 1));
    expect_sum("arst_post", 16'd36, 1'b0, 1'b0);
    xfer("arst_post");

    // random traffic against the row-sum model
    pending   = 1'b0;
    rows_done = 0;
    terms.delete();
    for (int i = 0; i < 600; i++) begin
      clr      = (i == 0) || ($urandom_range(0, 59) == 0);
      prod_vld = ($urandom_range(0, 3) != 0);
      prod_din = 16'($urandom);
      sum_rdy  = ($urandom_range(0, 2) != 0);
      check("rnd.rdy", prod_rdy, !pending);
      check("rnd.vld", sum_vld, pending);
      if (pending) begin
        check("rnd.sum", sum_dout, exp_sum);
        check("rnd.row", sum_row, exp_row);
        check("rnd.last", sum_last, exp_last);
      end
      if (clr) begin
        terms.delete();
        pending   = 1'b0;
        rows_done = 0;
      end else if (pending) begin
        if (sum_rdy) pending = 1'b0;
      end else if (prod_vld) begin
        terms.push_back(prod_din);
        if (terms.size() == 8) begin
          acc_m = '0;
          foreach (terms[k]) acc_m = acc_m + terms[k];
          exp_sum   = acc_m;
          exp_row   = (rows_done % 2) == 1;
          exp_last  = (rows_done % 2) == 1;
          rows_done = rows_done + 1;
          terms.delete();
          pending = 1'b1;
        end
      end
      @(posedge ap_clk);
      #1;
    end
    clr      = 1'b0;
    prod_vld = 1'b0;
    sum_rdy  = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
